// File: rtl/poly_wave_engine.sv
// Time-multiplexed N-voice DDS oscillator and mixer. Each frame sums one voice per cycle,
// scales the sum, and presents the sample on a valid/ready handshake.
module poly_wave_engine #(
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned PHASE_W    = 24,
   parameter int unsigned SAMPLE_W   = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           sample_tick_i,
   input  logic [NUM_VOICES-1:0]          voice_en_i,
   input  logic [2*NUM_VOICES-1:0]        voice_mode_i,
   input  logic [PHASE_W*NUM_VOICES-1:0]  voice_step_i,
   output logic [SAMPLE_W-1:0]            sample_out_o,
   output logic                           sample_valid_o,
   input  logic                           sample_ready_i,
   output logic                           busy_o,
   output logic                           overrun_o,
   input  logic                           clr_overrun_i
);

   localparam int unsigned IdxW = $clog2(NUM_VOICES);
   localparam int unsigned AccW = SAMPLE_W + IdxW;

   localparam logic [1:0] ModeSq    = 2'b00;
   localparam logic [1:0] ModeSaw   = 2'b01;
   localparam logic [1:0] ModeTri   = 2'b10;
   localparam logic [1:0] ModeNoise = 2'b11;

   localparam logic [SAMPLE_W-1:0] SqPos = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam logic [SAMPLE_W-1:0] SqNeg = {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StAccum, StScale} state_e;

   state_e                     state_q, state_d;
   logic [IdxW-1:0]            idx_q, idx_d;
   logic signed [AccW-1:0]     acc_q, acc_d;
   logic [15:0]                lfsr_q, lfsr_d;
   logic [PHASE_W-1:0]         phase_q [NUM_VOICES];
   logic [PHASE_W-1:0]         phase_d [NUM_VOICES];
   logic [SAMPLE_W-1:0]        sample_q, sample_d;
   logic                       valid_q, valid_d;
   logic                       overrun_q, overrun_d;

   logic                       last_voice;
   logic                       cur_en;
   logic [1:0]                 cur_mode;
   logic [PHASE_W-1:0]         cur_step;
   logic [PHASE_W-1:0]         cur_phase;
   logic [SAMPLE_W-1:0]        top, tri_t, tri_u, wave, contrib;
   logic                       overrun_set;

   // ---------------- FSM ----------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   assign last_voice = (idx_q == IdxW'(NUM_VOICES - 1));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (sample_tick_i) state_d = StAccum;
         StAccum: if (last_voice) state_d = StScale;
         StScale: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy_o = (state_q == StAccum) || (state_q == StScale);
   end

   // ---------------- voice datapath ----------------
   always_comb begin
      cur_en    = voice_en_i[idx_q];
      cur_mode  = voice_mode_i[2*int'(idx_q) +: 2];
      cur_step  = voice_step_i[PHASE_W*int'(idx_q) +: PHASE_W];
      cur_phase = phase_q[idx_q];
      top       = cur_phase[PHASE_W-1 -: SAMPLE_W];
      tri_t     = cur_phase[PHASE_W-2 -: SAMPLE_W];
      tri_u     = cur_phase[PHASE_W-1] ? ~tri_t : tri_t;
      wave      = '0;
      unique case (cur_mode)
         ModeSq:    wave = cur_phase[PHASE_W-1] ? SqNeg : SqPos;
         ModeSaw:   wave = {~top[SAMPLE_W-1], top[SAMPLE_W-2:0]};
         ModeTri:   wave = {~tri_u[SAMPLE_W-1], tri_u[SAMPLE_W-2:0]};
         ModeNoise: wave = lfsr_q[15 -: SAMPLE_W];
         default:   wave = '0;
      endcase
      contrib = cur_en ? wave : '0;
   end

   always_comb begin
      idx_d   = idx_q;
      acc_d   = acc_q;
      lfsr_d  = lfsr_q;
      phase_d = phase_q;
      if (state_q == StIdle && sample_tick_i) begin
         idx_d = '0;
         acc_d = '0;
      end else if (state_q == StAccum) begin
         idx_d = idx_q + 1'b1;
         acc_d = acc_q + AccW'(signed'(contrib));
         // Disabled voices park at phase 0 so a re-enable starts cleanly.
         phase_d[idx_q] = cur_en ? cur_phase + cur_step : '0;
         if (cur_en && cur_mode == ModeNoise) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
         end
      end
   end

   // ---------------- output handshake ----------------
   always_comb begin
      sample_d    = sample_q;
      valid_d     = valid_q;
      overrun_set = 1'b0;
      if (state_q == StScale) begin
         // Top SAMPLE_W bits of the accumulator are acc >>> log2(NUM_VOICES).
         sample_d    = acc_q[AccW-1 -: SAMPLE_W];
         valid_d     = 1'b1;
         overrun_set = valid_q && !sample_ready_i;
      end else if (valid_q && sample_ready_i) begin
         valid_d = 1'b0;
      end
      if (sample_tick_i && state_q != StIdle) overrun_set = 1'b1;
      overrun_d = overrun_set ? 1'b1 : (clr_overrun_i ? 1'b0 : overrun_q);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q     <= '0;
         acc_q     <= '0;
         lfsr_q    <= 16'hACE1;
         sample_q  <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         for (int i = 0; i < int'(NUM_VOICES); i++) phase_q[i] <= '0;
      end else begin
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         lfsr_q    <= lfsr_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         phase_q   <= phase_d;
      end
   end

   assign sample_out_o   = sample_q;
   assign sample_valid_o = valid_q;
   assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_poly_wave_engine.sv
// Directed bench for poly_wave_engine (4 voices, 24-bit phase, 16-bit samples).
module tb_poly_wave_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sample_tick = 1'b0;
   logic [3:0]  voice_en = '0;
   logic [7:0]  voice_mode = '0;
   logic [95:0] voice_step = '0;
   logic [15:0] sample_out;
   logic        sample_valid;
   logic        sample_ready = 1'b0;
   logic        busy;
   logic        overrun;
   logic        clr_overrun = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   poly_wave_engine #(.NUM_VOICES(4), .PHASE_W(24), .SAMPLE_W(16)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .sample_tick_i  (sample_tick),
      .voice_en_i     (voice_en),
      .voice_mode_i   (voice_mode),
      .voice_step_i   (voice_step),
      .sample_out_o   (sample_out),
      .sample_valid_o (sample_valid),
      .sample_ready_i (sample_ready),
      .busy_o         (busy),
      .overrun_o      (overrun),
      .clr_overrun_i  (clr_overrun)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sample_tick = 1'b0;
      sample_ready = 1'b0;
      clr_overrun = 1'b0;
      voice_en = '0;
      voice_mode = '0;
      voice_step = '0;
      cyc(2);
      rst = 1'b0;
      cyc(1);
   endtask

   task automatic set_voice(input int i, input logic en, input logic [1:0] mode,
                            input logic [23:0] step);
      voice_en[i]          = en;
      voice_mode[2*i +: 2] = mode;
      voice_step[24*i +: 24] = step;
   endtask

   // Pulse a tick and return how many cycles after it valid rose (-1 on timeout).
   task automatic tick_wait(output int lat);
      sample_tick = 1'b1;
      cyc(1);
      sample_tick = 1'b0;
      lat = -1;
      for (int k = 1; k <= 30; k++) begin
         if (sample_valid) begin
            lat = k;
            break;
         end
         cyc(1);
      end
   endtask

   task automatic accept();
      sample_ready = 1'b1;
      cyc(1);
      sample_ready = 1'b0;
   endtask

   task automatic test_reset();
      int lat;
      do_reset();
      n_tests++;
      if (sample_out !== 16'd0) begin
         n_fail++; $display("FAIL reset_sample_out got %0h want 0", sample_out);
      end
      n_tests++;
      if (sample_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid got %b want 0", sample_valid);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy got %b want 0", busy);
      end
      n_tests++;
      if (overrun !== 1'b0) begin
         n_fail++; $display("FAIL reset_overrun got %b want 0", overrun);
      end
      for (int i = 0; i < 4; i++) set_voice(i, 1'b1, 2'b00, 24'd0);
      tick_wait(lat);
      n_tests++;
      if (lat != 6) begin
         n_fail++; $display("FAIL first_latency got %0d want 6", lat);
      end
      n_tests++;
      if (sample_out !== 16'sd32767) begin
         n_fail++; $display("FAIL all_sq_sample got %0d want 32767", $signed(sample_out));
      end
      accept();
      n_tests++;
      if (sample_valid !== 1'b0) begin
         n_fail++; $display("FAIL accept_clears_valid got %b want 0", sample_valid);
      end
   endtask

   task automatic run_single(input string name, input logic [1:0] mode, input logic [23:0] step,
                             input int e0, input int e1, input int e2, input int e3);
      int lat;
      int exp_v [4];
      exp_v = '{e0, e1, e2, e3};
      do_reset();
      set_voice(0, 1'b1, mode, step);
      for (int f = 0; f < 4; f++) begin
         tick_wait(lat);
         n_tests++;
         if (lat < 0 || sample_out !== 16'(exp_v[f])) begin
            n_fail++;
            $display("FAIL %s frame%0d got %0d (lat %0d) want %0d", name, f,
                     $signed(sample_out), lat, exp_v[f]);
         end
         accept();
      end
   endtask

   task automatic test_noise();
      int lat;
      do_reset();
      set_voice(0, 1'b1, 2'b11, 24'd0);
      tick_wait(lat);
      n_tests++;
      if (sample_out !== 16'(-5320)) begin
         n_fail++; $display("FAIL noise_frame0 got %0d want -5320", $signed(sample_out));
      end
      accept();
      tick_wait(lat);
      n_tests++;
      if (sample_out !== 16'(5744)) begin
         n_fail++; $display("FAIL noise_frame1 got %0d want 5744", $signed(sample_out));
      end
      accept();
   endtask

   task automatic test_mix();
      int lat;
      do_reset();
      set_voice(0, 1'b1, 2'b00, 24'd0);
      set_voice(1, 1'b1, 2'b01, 24'd0);
      set_voice(2, 1'b0, 2'b11, 24'd0);
      set_voice(3, 1'b1, 2'b00, 24'd0);
      tick_wait(lat);
      n_tests++;
      if (sample_out !== 16'(8191)) begin
         n_fail++; $display("FAIL mix_sample got %0d want 8191", $signed(sample_out));
      end
      accept();
      // Disabled noise voice above must not have advanced the shared LFSR.
      voice_en = 4'b0000;
      set_voice(0, 1'b1, 2'b11, 24'd0);
      tick_wait(lat);
      n_tests++;
      if (sample_out !== 16'(-5320)) begin
         n_fail++; $display("FAIL mix_lfsr_idle got %0d want -5320", $signed(sample_out));
      end
      accept();
   endtask

   task automatic test_handshake();
      int lat;
      do_reset();
      set_voice(0, 1'b1, 2'b00, 24'd0);
      tick_wait(lat);
      cyc(5);
      n_tests++;
      if (sample_valid !== 1'b1 || sample_out !== 16'(8191)) begin
         n_fail++;
         $display("FAIL hold_while_valid got v=%b %0d want v=1 8191", sample_valid,
                  $signed(sample_out));
      end
      accept();
      n_tests++;
      if (sample_valid !== 1'b0) begin
         n_fail++; $display("FAIL hs_accept got %b want 0", sample_valid);
      end
   endtask

   task automatic test_overrun();
      do_reset();
      set_voice(0, 1'b1, 2'b01, 24'h400000);
      sample_tick = 1'b1;
      cyc(1);
      sample_tick = 1'b0;
      cyc(9);
      n_tests++;
      if (sample_valid !== 1'b1 || overrun !== 1'b0 || sample_out !== 16'(-8192)) begin
         n_fail++;
         $display("FAIL ovr_first got v=%b o=%b %0d want v=1 o=0 -8192", sample_valid, overrun,
                  $signed(sample_out));
      end
      cyc(10);
      sample_tick = 1'b1;
      cyc(1);
      sample_tick = 1'b0;
      cyc(8);
      n_tests++;
      if (overrun !== 1'b1 || sample_valid !== 1'b1 || sample_out !== 16'(-4096)) begin
         n_fail++;
         $display("FAIL ovr_second got v=%b o=%b %0d want v=1 o=1 -4096", sample_valid, overrun,
                  $signed(sample_out));
      end
      clr_overrun = 1'b1;
      cyc(1);
      clr_overrun = 1'b0;
      n_tests++;
      if (overrun !== 1'b0) begin
         n_fail++; $display("FAIL ovr_clear got %b want 0", overrun);
      end
      accept();
   endtask

   task automatic test_tick_busy();
      do_reset();
      set_voice(0, 1'b1, 2'b00, 24'd0);
      sample_tick = 1'b1;
      cyc(1);
      sample_tick = 1'b0;
      cyc(1);
      sample_tick = 1'b1;
      cyc(1);
      sample_tick = 1'b0;
      cyc(3);
      n_tests++;
      if (sample_valid !== 1'b1 || sample_out !== 16'(8191) || overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL tick_busy got v=%b o=%b %0d want v=1 o=1 8191", sample_valid, overrun,
                  $signed(sample_out));
      end
      accept();
      cyc(10);
      n_tests++;
      if (sample_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL tick_busy_single got v=%b busy=%b want 0 0", sample_valid, busy);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      do_reset();
      set_voice(0, 1'b1, 2'b00, 24'h800000);
      tick_wait(lat);
      sample_tick = 1'b1;
      cyc(1);
      sample_tick = 1'b0;
      cyc(4);
      sample_ready = 1'b1;
      cyc(1);
      sample_ready = 1'b0;
      n_tests++;
      if (sample_valid !== 1'b1 || sample_out !== 16'(-8192) || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b got v=%b o=%b %0d want v=1 o=0 -8192", sample_valid, overrun,
                  $signed(sample_out));
      end
      accept();
   endtask

   task automatic test_reset_mid();
      int lat;
      do_reset();
      set_voice(0, 1'b1, 2'b00, 24'h800000);
      tick_wait(lat);
      accept();
      sample_tick = 1'b1;
      cyc(1);
      sample_tick = 1'b0;
      cyc(1);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || sample_valid !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset got busy=%b v=%b want 0 0", busy, sample_valid);
      end
      cyc(10);
      n_tests++;
      if (sample_valid !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_no_sample got %b want 0", sample_valid);
      end
      tick_wait(lat);
      n_tests++;
      if (lat < 0 || sample_out !== 16'(8191)) begin
         n_fail++; $display("FAIL mid_reset_f0 got %0d want 8191", $signed(sample_out));
      end
      accept();
      tick_wait(lat);
      n_tests++;
      if (lat < 0 || sample_out !== 16'(-8192)) begin
         n_fail++; $display("FAIL mid_reset_f1 got %0d want -8192", $signed(sample_out));
      end
      accept();
   endtask

   initial begin
      test_reset();
      run_single("sq_alt", 2'b00, 24'h800000, 8191, -8192, 8191, -8192);
      run_single("tri", 2'b10, 24'h400000, -8192, 0, 8191, -1);
      test_noise();
      test_mix();
      test_handshake();
      test_overrun();
      test_tick_busy();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
